ternary_layer_seq: RTL and testbench

TERNARY_LAYER_SEQ -- requirements
Module: ternary_layer_seq

---
 rtl/ternary_layer_seq_pkg.sv | 30 +++
 rtl/ternary_layer_seq_mac.sv | 41 ++++
 rtl/ternary_layer_seq.sv | 127 ++++++++++++
 tb/tb_ternary_layer_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_layer_seq_pkg.sv
// Shared definitions for the ternary layer sequencer: weight encodings,
// FSM states, accumulator width and the activation clamp.
package ternary_layer_seq_pkg;

  localparam int ACC_W = 7;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_ILL  = 2'b10;

  localparam logic signed [ACC_W-1:0] ACT_MIN = 7'sd0;
  localparam logic signed [ACC_W-1:0] ACT_MAX = 7'sd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  // Saturate a signed sum into the 2-bit activation range.
  function automatic logic [1:0] act_clamp(input logic signed [ACC_W-1:0] a);
    if (a < ACT_MIN)      return ACT_MIN[1:0];
    else if (a > ACT_MAX) return ACT_MAX[1:0];
    else                  return a[1:0];
  endfunction

endpackage

// File: rtl/ternary_layer_seq_mac.sv
// Ternary multiply-accumulate: acc_out <= acc_in + x*w, w in {0,+1,-1}.
// acc_sum exposes the next value so the owner can capture a finished sum
// on the same edge it lands in acc_out. The illegal code adds nothing.
module ternary_mac import ternary_layer_seq_pkg::*; (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              x,
  input  logic [1:0]              w,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [ACC_W-1:0] acc_sum,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ill
);

  logic signed [ACC_W-1:0] prod;

  // Decode the weight into a signed product and flag the illegal code.
  always_comb begin
    prod = '0;
    ill  = 1'b0;
    if (en) begin
      case (w)
        W_POS:   prod = {{(ACC_W-2){1'b0}}, x};
        W_NEG:   prod = -{{(ACC_W-2){1'b0}}, x};
        W_ILL:   ill  = 1'b1;
        default: prod = '0;
      endcase
    end
  end

  // Modulo-128 add; wraps naturally at ACC_W bits.
  assign acc_sum = acc_in + prod;

  // Accumulator register; with en low it simply reloads acc_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_out <= '0;
    else        acc_out <= acc_sum;
  end

endmodule

// File: rtl/ternary_layer_seq.sv
// Sequential ternary neural layer: for each of N_OUT neurons, fetch N_IN
// ternary weights from an external one-cycle-latency memory, accumulate
// against captured 2-bit inputs, and emit the raw sum plus clamped activation.
module ternary_layer_seq import ternary_layer_seq_pkg::*; #(
  parameter  int N_IN  = 8,
  parameter  int N_OUT = 4,
  localparam int AW    = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [2*N_IN-1:0]       in_vec,
  output logic [AW-1:0]           w_addr,
  input  logic [1:0]              w_data,
  output logic                    busy,
  output logic                    out_valid,
  output logic [OW-1:0]           out_idx,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [1:0]              out_act,
  output logic                    done,
  output logic                    err
);

  localparam int             IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0]  I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0]  O_LAST = OW'(N_OUT - 1);

  state_t                  state;
  logic [IW-1:0]           i;
  logic [OW-1:0]           o;
  logic [AW-1:0]           ptr;   // address of element i of neuron o (= o*N_IN+i)
  logic [N_IN-1:0][1:0]    in_q;
  logic                    mac_en, mac_ill;
  logic signed [ACC_W-1:0] acc_in, acc_sum, acc_out;

  assign mac_en = (state == S_ACC);
  // PRIME zeroes the accumulator by feeding 0 back instead of acc_out.
  assign acc_in = (state == S_PRIME) ? '0 : acc_out;

  ternary_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (mac_en),
    .x       (in_q[i]),
    .w       (w_data),
    .acc_in  (acc_in),
    .acc_sum (acc_sum),
    .acc_out (acc_out),
    .ill     (mac_ill)
  );

  assign busy = state inside {S_PRIME, S_ACC, S_EMIT};

  // Prefetch address: PRIME asks for element 0, each ACC cycle for i+1.
  // ptr walks linearly, so no o*N_IN multiply is needed.
  always_comb begin
    w_addr = '0;
    case (state)
      S_PRIME: w_addr = ptr;
      S_ACC:   w_addr = ptr + AW'(1);
      default: w_addr = '0;
    endcase
  end

  // Sequencer with registered result/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      i         <= '0;
      o         <= '0;
      ptr       <= '0;
      in_q      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_acc   <= '0;
      out_act   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (mac_ill) err <= 1'b1;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            in_q  <= in_vec;
            i     <= '0;
            o     <= '0;
            ptr   <= '0;
            err   <= 1'b0;
            state <= S_PRIME;
          end
          S_PRIME: state <= S_ACC;
          S_ACC: begin
            i   <= i + 1'b1;
            ptr <= ptr + 1'b1;
            if (i == I_LAST) begin
              // Capture the final sum as it lands, so EMIT presents it.
              i         <= '0;
              out_valid <= 1'b1;
              out_idx   <= o;
              out_acc   <= acc_sum;
              out_act   <= act_clamp(acc_sum);
              state     <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (o == O_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              o     <= o + 1'b1;
              state <= S_PRIME;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ternary_layer_seq.sv
// Bench for ternary_layer_seq: directed and random layer passes against a
// plain-arithmetic reference (dot products from the weight table), plus
// timing, abort, reset and the wide-input corner on a second instance.
module tb_ternary_layer_seq;

  localparam int NI   = 8;
  localparam int NO   = 4;
  localparam int P    = NI + 2;
  localparam int PASS = NO * P;
  localparam int NI2  = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [2*NI-1:0] in_vec = '0;
  logic [4:0] w_addr;
  logic [1:0] w_data = '0;
  logic busy, out_valid, done, err;
  logic [1:0] out_idx, out_act;
  logic signed [6:0] out_acc;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic [2*NI2-1:0] in_vec2 = '0;
  logic [4:0] w_addr2;
  logic [1:0] w_data2 = '0;
  logic busy2, out_valid2, done2, err2;
  logic [0:0] out_idx2;
  logic [1:0] out_act2;
  logic signed [6:0] out_acc2;

  logic [1:0] wmem  [0:31];
  logic [1:0] wmem2 [0:31];
  logic [2*NI-1:0] cap_vec;

  int passes = 0;
  int total  = 0;

  ternary_layer_seq #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_vec(in_vec),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .out_valid(out_valid),
    .out_idx(out_idx), .out_acc(out_acc), .out_act(out_act), .done(done), .err(err)
  );

  ternary_layer_seq #(.N_IN(NI2), .N_OUT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .in_vec(in_vec2),
    .w_addr(w_addr2), .w_data(w_data2), .busy(busy2), .out_valid(out_valid2),
    .out_idx(out_idx2), .out_acc(out_acc2), .out_act(out_act2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  // Weight memories with one cycle of read latency.
  always @(posedge clk) begin
    w_data  <= wmem[w_addr];
    w_data2 <= wmem2[w_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic int wv(input logic [1:0] w);
    if (w == 2'b01) return 1;
    if (w == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int ref_sum(input int n);
    int s = 0;
    for (int k = 0; k < NI; k++) s += int'(cap_vec[2*k +: 2]) * wv(wmem[n*NI + k]);
    return s;
  endfunction

  function automatic int ref_act(input int s);
    return (s < 0) ? 0 : (s > 3) ? 3 : s;
  endfunction

  // Run one pass starting at the current negedge. restart_e / abort_e are the
  // edge numbers (edge 0 samples start) at which start / abort get sampled.
  task automatic run_pass(input int restart_e, input int abort_e);
    int  s [NO];
    int  last_n = -1;
    bit  live, vexp, exp_err = 1'b0;
    cap_vec = in_vec;
    for (int n = 0; n < NO; n++) s[n] = ref_sum(n);
    for (int n = 0; n < NO; n++)
      for (int k = 0; k < NI; k++)
        if (wmem[n*NI + k] == 2'b10 && n*P + 2 + k <= abort_e) exp_err = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= PASS + 1; k++) begin
      @(negedge clk);
      live = (k < abort_e);
      vexp = live && k < PASS && (k % P) == NI + 1;
      chk("busy", busy, live && k < PASS);
      chk("out_valid", out_valid, vexp);
      chk("done", done, live && k == PASS);
      if (k == 0) chk("err_cleared_by_start", err, 0);
      if (live && k < PASS && (k % P) == 0) chk("w_addr_prime", w_addr, (k / P) * NI);
      if (vexp) begin
        last_n = k / P;
        chk("out_idx", out_idx, last_n);
        chk("out_acc", $signed(out_acc), s[last_n]);
        chk("out_act", out_act, ref_act(s[last_n]));
      end
      start = (k + 1 == restart_e);
      abort = (k + 1 == abort_e);
      if (k == 1) in_vec = ~in_vec;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("err_end", err, exp_err);
    chk("w_addr_idle", w_addr, 0);
    if (last_n >= 0) begin
      chk("hold_idx", out_idx, last_n);
      chk("hold_acc", $signed(out_acc), s[last_n]);
    end
  endtask

  task automatic rand_weights(input bit with_ill);
    logic [1:0] codes [3];
    codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b11;
    for (int a = 0; a < 32; a++) wmem[a] = codes[$urandom_range(0, 2)];
    if (with_ill) wmem[$urandom_range(0, NI*NO - 1)] = 2'b10;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin wmem[a] = 2'b00; wmem2[a] = 2'b00; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_act", out_act, 0);

    // Directed pass, start on the first edge after release
    rst_n = 1'b1;
    in_vec = '1;
    for (int k = 0; k < NI; k++) begin
      wmem[0*NI + k] = 2'b01;
      wmem[1*NI + k] = 2'b11;
      wmem[2*NI + k] = 2'b00;
      wmem[3*NI + k] = (k == 0) ? 2'b01 : 2'b00;
    end
    run_pass(1000, 1000);

    // Illegal weight in an otherwise +1 neuron
    for (int k = 0; k < NI; k++) in_vec[2*k +: 2] = 2'b01;
    for (int a = 0; a < NI*NO; a++) wmem[a] = 2'b01;
    wmem[2*NI + 5] = 2'b10;
    run_pass(1000, 1000);

    // Random passes (first also checks err clears on start)
    for (int t = 0; t < 2; t++) begin
      in_vec = 16'($urandom);
      rand_weights(t == 1);
      run_pass(1000, 1000);
    end

    // Ignored restart at edge 5, abort sampled at edge 16, err retained
    in_vec = 16'($urandom);
    rand_weights(1'b0);
    wmem[3] = 2'b10;
    run_pass(5, 16);
    chk("abort_err_kept", err, 1);

    in_vec = 16'($urandom);
    rand_weights(1'b0);
    run_pass(1000, 1000);

    // Reset mid-ACC with an illegal weight already consumed
    in_vec = 16'($urandom);
    rand_weights(1'b0);
    wmem[0] = 2'b10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_out_acc", out_acc, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(1000, 1000);

    for (int t = 0; t < 3; t++) begin
      in_vec = 16'($urandom);
      rand_weights(t == 2);
      run_pass(1000, 1000);
    end

    // Widest legal neuron: +63 and -63
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < NI2; a++) wmem2[a] = (t == 0) ? 2'b01 : 2'b11;
      in_vec2 = '1;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= NI2 + 3; k++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (k == NI2) chk("w21_busy", busy2, 1);
        if (k == NI2 + 1) begin
          chk("w21_valid", out_valid2, 1);
          chk("w21_acc", $signed(out_acc2), (t == 0) ? 63 : -63);
          chk("w21_act", out_act2, (t == 0) ? 3 : 0);
        end
        if (k == NI2 + 2) chk("w21_done", done2, 1);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
